// File: rtl/cda_pkg.sv
// Shared definitions for the sequential carry-disregard (CDA) multiplier:
// controller state encoding, product-width helper and error-counter width.
package cda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cda_state_e;

  // Width of the saturating error-event counter (error monitor builds only).
  localparam int ERR_CNT_W = 16;

  // An AW x BW product always fits in AW+BW bits.
  function automatic int cda_pw(input int aw, input int bw);
    return aw + bw;
  endfunction

endpackage

// File: rtl/cda_row_step.sv
// One row of the shift-and-combine multiplier: forms the partial product for
// a single multiplier bit and folds it into the accumulator, either by adding
// (exact) or by XOR (carry-disregard approximation).
module cda_row_step
  import cda_pkg::*;
#(
  parameter int AW = 8,
  parameter int BW = 4,
  parameter int CW = 2,
  localparam int PW = cda_pw(AW, BW)
) (
  input  logic [PW-1:0] acc_i,
  input  logic [AW-1:0] a_i,
  input  logic          b_bit_i,
  input  logic [CW-1:0] row_i,
  input  logic          exact_i,
  output logic [PW-1:0] acc_o
);

  logic [PW-1:0] pp;

  // Partial product for this row, then combine it in the selected mode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pp = '0;
    if (b_bit_i) pp = PW'(a_i) << row_i;
    acc_o = exact_i ? (acc_i + pp) : (acc_i ^ pp);
  end

endmodule

// File: rtl/cda_seq_mul.sv
// Sequential AW x BW multiplier, one multiplier row per clock, with
// valid/ready handshakes on both sides and a per-transaction choice of exact
// or carry-disregard (carry-less) product.
// Optional build macro CDA_ERR_MON_EN adds a shadow accumulator in the other
// mode, an out_err output (exact minus approximate product) and a saturating
// err_cnt of handshaken results whose error is non-zero.
module cda_seq_mul
  import cda_pkg::*;
#(
  parameter int AW = 8,
  parameter int BW = 4,
  localparam int PW = cda_pw(AW, BW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          in_exact,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_r,
  output logic          out_exact
`ifdef CDA_ERR_MON_EN
  ,
  output logic [PW-1:0]        out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] LAST_ROW = CW'(BW - 1);

  cda_state_e    state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] res_q, res_d;
  logic          res_exact_q, res_exact_d;
  logic [PW-1:0] acc_step;

  cda_row_step #(.AW(AW), .BW(BW), .CW(CW)) u_step (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .b_bit_i (b_q[cnt_q]),
    .row_i   (cnt_q),
    .exact_i (mode_q),
    .acc_o   (acc_step)
  );

`ifdef CDA_ERR_MON_EN
  logic [PW-1:0]        sh_q, sh_d, sh_step;
  logic [PW-1:0]        err_q, err_d, err_next;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;

  // The shadow accumulator always runs in the opposite mode, so at the last
  // row both the exact and the approximate product are available.
  cda_row_step #(.AW(AW), .BW(BW), .CW(CW)) u_shadow (
    .acc_i   (sh_q),
    .a_i     (a_q),
    .b_bit_i (b_q[cnt_q]),
    .row_i   (cnt_q),
    .exact_i (~mode_q),
    .acc_o   (sh_step)
  );

  // Carry-less product never exceeds the integer product, so no wrap here.
  assign err_next = mode_q ? (acc_step - sh_step) : (sh_step - acc_step);
`endif

  // Controller and datapath next-state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_exact_d = res_exact_q;
`ifdef CDA_ERR_MON_EN
    sh_d   = sh_q;
    err_d  = err_q;
    ecnt_d = ecnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = in_exact;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef CDA_ERR_MON_EN
          sh_d = '0;
`endif
        end
      end
      RUN: begin
        // Every row costs a cycle, zero multiplier bits included, so the
        // latency never depends on the operands.
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
`ifdef CDA_ERR_MON_EN
        sh_d = sh_step;
`endif
        if (cnt_q == LAST_ROW) begin
          res_d       = acc_step;
          res_exact_d = mode_q;
          cnt_d       = '0;
          state_d     = DONE;
`ifdef CDA_ERR_MON_EN
          err_d = err_next;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef CDA_ERR_MON_EN
          if (err_q != '0 && ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset also aborts a transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_exact_q <= 1'b0;
`ifdef CDA_ERR_MON_EN
      sh_q   <= '0;
      err_q  <= '0;
      ecnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_exact_q <= res_exact_d;
`ifdef CDA_ERR_MON_EN
      sh_q   <= sh_d;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_r     = res_q;
  assign out_exact = res_exact_q;
`ifdef CDA_ERR_MON_EN
  assign out_err = err_q;
  assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_cda_seq_mul.sv
// Self-checking bench for cda_seq_mul: a default 8x4 instance for the directed
// cases and a 12x6 instance for randomised traffic, both checked against an
// integer / carry-less-polynomial reference model. Honors CDA_ERR_MON_EN.
module tb_cda_seq_mul;

  localparam int AW_S = 8;
  localparam int BW_S = 4;
  localparam int PW_S = AW_S + BW_S;
  localparam int AW_W = 12;
  localparam int BW_W = 6;
  localparam int PW_W = AW_W + BW_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic            s_in_valid, s_in_ready, s_in_exact, s_out_valid, s_out_ready, s_out_exact;
  logic [AW_S-1:0] s_in_a;
  logic [BW_S-1:0] s_in_b;
  logic [PW_S-1:0] s_out_r;
  logic            w_in_valid, w_in_ready, w_in_exact, w_out_valid, w_out_ready, w_out_exact;
  logic [AW_W-1:0] w_in_a;
  logic [BW_W-1:0] w_in_b;
  logic [PW_W-1:0] w_out_r;
`ifdef CDA_ERR_MON_EN
  logic [PW_S-1:0] s_out_err;
  logic [15:0]     s_err_cnt;
  logic [PW_W-1:0] w_out_err;
  logic [15:0]     w_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int s_cnt_exp = 0;
  int w_cnt_exp = 0;

  cda_seq_mul #(.AW(AW_S), .BW(BW_S)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_exact(s_in_exact), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_r(s_out_r), .out_exact(s_out_exact)
`ifdef CDA_ERR_MON_EN
    , .out_err(s_out_err), .err_cnt(s_err_cnt)
`endif
  );

  cda_seq_mul #(.AW(AW_W), .BW(BW_W)) u_dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .in_exact(w_in_exact), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_r(w_out_r), .out_exact(w_out_exact)
`ifdef CDA_ERR_MON_EN
    , .out_err(w_out_err), .err_cnt(w_err_cnt)
`endif
  );

  // Reference model: integer product and carry-less (GF(2) polynomial) product.
  function automatic int unsigned clmul(input int unsigned a, input int unsigned b, input int bw);
    int unsigned r;
    r = 0;
    for (int j = 0; j < bw; j++) if (b[j]) r = r ^ (a << j);
    return r;
  endfunction

  function automatic int unsigned ref_prod(input int unsigned a, input int unsigned b,
                                           input int bw, input logic ex);
    return ex ? a * b : clmul(a, b, bw);
  endfunction

  // Directed vectors for the 8x4 instance.
  logic [7:0]  d_a   [8] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h00, 8'h00};
  logic [3:0]  d_b   [8] = '{4'hF, 4'hF, 4'h3, 4'h3, 4'h1, 4'h1, 4'hF, 4'hF};
  logic        d_ex  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [11:0] d_r   [8] = '{12'hEF1, 12'h505, 12'h011, 12'h02D, 12'h0A5, 12'h0A5, 12'h000, 12'h000};
  logic [11:0] d_err [8] = '{12'h9EC, 12'h9EC, 12'h01C, 12'h01C, 12'h000, 12'h000, 12'h000, 12'h000};

  // Runs one transaction on the 8x4 instance; called and returns on a negedge.
  task automatic small_txn(input logic [7:0] a, input logic [3:0] b, input logic ex,
                           input int stall, output logic [11:0] r, output logic rex,
                           output int lat, output logic [11:0] err, output logic ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!s_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_in_ready) ok = 1'b0;
    s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_exact = ex;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_in_a = AW_S'($urandom); s_in_b = BW_S'($urandom); s_in_exact = 1'($urandom);
    lat = 0;
    while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!s_out_valid) ok = 1'b0;
    r = s_out_r; rex = s_out_exact; err = '0;
`ifdef CDA_ERR_MON_EN
    err = s_out_err;
`endif
    repeat (stall) @(negedge clk);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    if (a * b != clmul(a, b, BW_S) && s_cnt_exp < 65535) s_cnt_exp++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_exact = 0; s_out_ready = 0;
    w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_exact = 0; w_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s_cnt_exp = 0; w_cnt_exp = 0;
    n_cmp++;
    if ({s_in_ready, s_out_valid, s_out_exact, s_out_r} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      n_bad++;
      $display("FAIL reset_s: rdy/vld/ex/r got %b %b %b %h, want 1 0 0 000",
               s_in_ready, s_out_valid, s_out_exact, s_out_r);
    end
    n_cmp++;
    if ({w_in_ready, w_out_valid, w_out_exact, w_out_r} !== {1'b1, 1'b0, 1'b0, 18'h0}) begin
      n_bad++;
      $display("FAIL reset_w: rdy/vld/ex/r got %b %b %b %h, want 1 0 0 00000",
               w_in_ready, w_out_valid, w_out_exact, w_out_r);
    end
`ifdef CDA_ERR_MON_EN
    n_cmp++;
    if ({s_out_err, s_err_cnt, w_out_err, w_err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_err: got s_err=%h s_cnt=%h w_err=%h w_cnt=%h, want all 0",
               s_out_err, s_err_cnt, w_out_err, w_err_cnt);
    end
`endif
  endtask

  task automatic test_directed();
    logic [11:0] r, err;
    logic rex, ok;
    int lat;
    for (int i = 0; i < 8; i++) begin
      small_txn(d_a[i], d_b[i], d_ex[i], i % 3, r, rex, lat, err, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL dir_timeout[%0d]: handshake never completed", i); end
      n_cmp++;
      if (r !== d_r[i]) begin n_bad++; $display("FAIL dir_r[%0d]: got %h want %h", i, r, d_r[i]); end
      n_cmp++;
      if (rex !== d_ex[i]) begin n_bad++; $display("FAIL dir_exact[%0d]: got %b want %b", i, rex, d_ex[i]); end
      n_cmp++;
      if (lat !== BW_S) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, BW_S); end
`ifdef CDA_ERR_MON_EN
      n_cmp++;
      if (err !== d_err[i]) begin n_bad++; $display("FAIL dir_err[%0d]: got %h want %h", i, err, d_err[i]); end
      n_cmp++;
      if (s_err_cnt !== 16'(s_cnt_exp)) begin
        n_bad++; $display("FAIL dir_errcnt[%0d]: got %0d want %0d", i, s_err_cnt, s_cnt_exp);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_r;
    int n;
    exp_r = 12'(ref_prod(8'h5A, 4'hB, BW_S, 1'b1));
    s_in_valid = 1'b1; s_in_a = 8'h5A; s_in_b = 4'hB; s_in_exact = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 100) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({s_out_valid, s_out_r, s_out_exact, s_in_ready} !== {1'b1, exp_r, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld/r/ex/rdy got %b %h %b %b, want 1 %h 1 0",
                 c, s_out_valid, s_out_r, s_out_exact, s_in_ready, exp_r);
      end
      s_in_valid = (c == 4);
      s_in_a = 8'h33; s_in_b = 4'h7; s_in_exact = 1'b0;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    n_cmp++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL bp_release: vld/rdy got %b %b, want 0 1", s_out_valid, s_in_ready);
    end
    repeat (BW_S + 3) @(negedge clk);
    n_cmp++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL bp_no_accept: vld/rdy got %b %b, want 0 1", s_out_valid, s_in_ready);
    end
    if (8'h5A * 4'hB != clmul(8'h5A, 4'hB, BW_S) && s_cnt_exp < 65535) s_cnt_exp++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] r, err;
    logic rex, ok;
    int lat;
    s_in_valid = 1'b1; s_in_a = 8'hFF; s_in_b = 4'hF; s_in_exact = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_cnt_exp = 0; w_cnt_exp = 0;
    n_cmp++;
    if ({s_in_ready, s_out_valid, s_out_r} !== {1'b1, 1'b0, 12'h000}) begin
      n_bad++;
      $display("FAIL rst_mid: rdy/vld/r got %b %b %h, want 1 0 000", s_in_ready, s_out_valid, s_out_r);
    end
`ifdef CDA_ERR_MON_EN
    n_cmp++;
    if (s_err_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", s_err_cnt); end
`endif
    repeat (BW_S + 2) @(negedge clk);
    n_cmp++;
    if (s_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_abort: out_valid got %b want 0", s_out_valid); end
    small_txn(8'h37, 4'h9, 1'b0, 1, r, rex, lat, err, ok);
    n_cmp++;
    if (ok !== 1'b1 || r !== 12'(clmul(8'h37, 4'h9, BW_S))) begin
      n_bad++;
      $display("FAIL rst_mid_next: ok=%b r got %h want %h", ok, r, 12'(clmul(8'h37, 4'h9, BW_S)));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [5];
    logic [3:0] tb [5];
    logic       te [5];
    int n;
    for (int k = 0; k < 5; k++) begin
      ta[k] = 8'($urandom); tb[k] = 4'($urandom); te[k] = 1'($urandom);
    end
    s_in_valid = 1'b1; s_in_a = ta[0]; s_in_b = tb[0]; s_in_exact = te[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept[%0d]: in_ready got %b want 0", k, s_in_ready); end
      s_in_a = ta[k+1]; s_in_b = tb[k+1]; s_in_exact = te[k+1];
      n = 0;
      while (!s_out_valid && n < 100) begin @(negedge clk); n++; end
      n_cmp++;
      if (n !== BW_S || s_out_r !== 12'(ref_prod(ta[k], tb[k], BW_S, te[k]))) begin
        n_bad++;
        $display("FAIL b2b_result[%0d]: lat %0d r %h, want lat %0d r %h", k, n, s_out_r,
                 BW_S, 12'(ref_prod(ta[k], tb[k], BW_S, te[k])));
      end
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      if (ta[k] * tb[k] != clmul(ta[k], tb[k], BW_S) && s_cnt_exp < 65535) s_cnt_exp++;
      n_cmp++;
      if (s_in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle[%0d]: in_ready got %b want 1", k, s_in_ready); end
    end
    // The fifth operand set is accepted on the next edge; let it drain.
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 100) begin @(negedge clk); n++; end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    if (ta[4] * tb[4] != clmul(ta[4], tb[4], BW_S) && s_cnt_exp < 65535) s_cnt_exp++;
  endtask

  task automatic test_random_small();
    logic [11:0] r, err;
    logic rex, ok;
    int lat;
    logic [7:0] a;
    logic [3:0] b;
    logic ex;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); b = 4'($urandom); ex = 1'($urandom);
      small_txn(a, b, ex, $urandom_range(0, 3), r, rex, lat, err, ok);
      n_cmp++;
      if (ok !== 1'b1 || lat !== BW_S || rex !== ex || r !== 12'(ref_prod(a, b, BW_S, ex))) begin
        n_bad++;
        $display("FAIL rnd_s[%0d]: a=%h b=%h ex=%b -> r %h ex %b lat %0d ok %b, want r %h lat %0d",
                 i, a, b, ex, r, rex, lat, ok, 12'(ref_prod(a, b, BW_S, ex)), BW_S);
      end
`ifdef CDA_ERR_MON_EN
      n_cmp++;
      if (err !== 12'(a * b - clmul(a, b, BW_S)) || s_err_cnt !== 16'(s_cnt_exp)) begin
        n_bad++;
        $display("FAIL rnd_s_err[%0d]: err %h cnt %0d, want %h %0d", i, err, s_err_cnt,
                 12'(a * b - clmul(a, b, BW_S)), s_cnt_exp);
      end
`endif
    end
  endtask

  task automatic test_random_wide();
    logic [AW_W-1:0] a;
    logic [BW_W-1:0] b;
    logic ex, ok;
    int lat, n;
    logic [PW_W-1:0] r, want;
    for (int i = 0; i < 1500; i++) begin
      a = (i % 50 == 0) ? '1 : AW_W'($urandom);
      b = (i % 70 == 0) ? '1 : BW_W'($urandom);
      ex = 1'($urandom);
      want = PW_W'(ref_prod(a, b, BW_W, ex));
      ok = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      n = 0;
      while (!w_in_ready && n < 100) begin @(negedge clk); n++; end
      if (!w_in_ready) ok = 1'b0;
      w_in_valid = 1'b1; w_in_a = a; w_in_b = b; w_in_exact = ex;
      @(negedge clk);
      w_in_valid = 1'b0; w_in_a = AW_W'($urandom); w_in_b = BW_W'($urandom); w_in_exact = 1'($urandom);
      lat = 0;
      while (!w_out_valid && lat < 100) begin
        w_out_ready = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      w_out_ready = 1'b0;
      if (!w_out_valid) ok = 1'b0;
      r = w_out_r;
      n_cmp++;
      if (ok !== 1'b1 || lat !== BW_W || w_out_exact !== ex || r !== want) begin
        n_bad++;
        $display("FAIL rnd_w[%0d]: a=%h b=%h ex=%b -> r %h ex %b lat %0d ok %b, want r %h lat %0d",
                 i, a, b, ex, r, w_out_exact, lat, ok, want, BW_W);
      end
`ifdef CDA_ERR_MON_EN
      n_cmp++;
      if (w_out_err !== PW_W'(a * b - clmul(a, b, BW_W))) begin
        n_bad++;
        $display("FAIL rnd_w_err[%0d]: got %h want %h", i, w_out_err, PW_W'(a * b - clmul(a, b, BW_W)));
      end
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w_out_ready = 1'b1;
      @(negedge clk);
      w_out_ready = 1'b0;
      if (a * b != clmul(a, b, BW_W) && w_cnt_exp < 65535) w_cnt_exp++;
    end
`ifdef CDA_ERR_MON_EN
    n_cmp++;
    if (w_err_cnt !== 16'(w_cnt_exp)) begin
      n_bad++; $display("FAIL rnd_w_errcnt: got %0d want %0d", w_err_cnt, w_cnt_exp);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_small();
    test_random_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
